nts_api_initiator: RTL and testbench

Bus initiator that drives the 12-bit-address / 32-bit-data external API (cs, we, address, write_data, read_data) from a valid/ready command stream. It is used by on-chip sequencers, such as the boot-time key loader and the debug UART bridge, to reach the engine, clock, cookie, keymem and debug register spaces through the API decoder. It converts each accepted command into single-cycle cs pulses. Reads may be issued as address-incrementing bursts. Read data is sampled at a fixed latency and returned on a valid/ready response stream.

---
 rtl/nts_api_initiator_pkg.sv | 15 +
 rtl/nts_api_initiator.sv | 132 +++++++++++++
 tb/tb_nts_api_initiator.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/nts_api_initiator_pkg.sv
// Shared widths and state encoding for the API bus initiator.
// Imported by the initiator and anything that decodes its state.
package nts_api_initiator_pkg;

    localparam int API_ADDR_WIDTH = 12;
    localparam int API_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/nts_api_initiator.sv
// Turns a valid/ready command stream into single-cycle API cs pulses and
// returns read data, optionally as address-incrementing bursts.
module nts_api_initiator
    import nts_api_initiator_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int COUNT_WIDTH  = 8
) (
    input  logic                      i_clk,
    input  logic                      i_areset,
    input  logic                      i_cmd_valid,
    output logic                      o_cmd_ready,
    input  logic                      i_cmd_we,
    input  logic [API_ADDR_WIDTH-1:0] i_cmd_address,
    input  logic [API_DATA_WIDTH-1:0] i_cmd_write_data,
    input  logic [COUNT_WIDTH-1:0]    i_cmd_count,
    output logic                      o_api_cs,
    output logic                      o_api_we,
    output logic [API_ADDR_WIDTH-1:0] o_api_address,
    output logic [API_DATA_WIDTH-1:0] o_api_write_data,
    input  logic [API_DATA_WIDTH-1:0] i_api_read_data,
    output logic                      o_rsp_valid,
    input  logic                      i_rsp_ready,
    output logic [API_DATA_WIDTH-1:0] o_rsp_data,
    output logic [API_ADDR_WIDTH-1:0] o_rsp_address,
    output logic                      o_rsp_last,
    output logic                      o_busy
);

    state_t                    state_q, state_d;
    logic                      we_q;
    logic [API_ADDR_WIDTH-1:0] addr_q;
    logic [API_DATA_WIDTH-1:0] wdata_q;
    logic [API_DATA_WIDTH-1:0] rdata_q;
    logic [COUNT_WIDTH-1:0]    remaining_q;
    logic [1:0]                lat_q;

    logic cmd_accept;
    logic capture;
    logic advance;
    logic lat_load;

    always_comb begin
        state_d    = state_q;
        cmd_accept = 1'b0;
        capture    = 1'b0;
        advance    = 1'b0;
        lat_load   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_cmd_valid) begin
                    cmd_accept = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = IDLE;
                end else if (READ_LATENCY == 0) begin
                    // Combinational responder: data is valid in the cs cycle.
                    capture = 1'b1;
                    state_d = RESP;
                end else begin
                    lat_load = 1'b1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (lat_q == 2'd1) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (i_rsp_ready) begin
                    if (remaining_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        advance = 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_areset) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            remaining_q <= '0;
            lat_q       <= '0;
        end else begin
            state_q <= state_d;
            if (cmd_accept) begin
                we_q        <= i_cmd_we;
                addr_q      <= i_cmd_address;
                wdata_q     <= i_cmd_write_data;
                remaining_q <= i_cmd_count;
            end
            if (lat_load) begin
                lat_q <= 2'(READ_LATENCY);
            end else if (state_q == WAIT) begin
                lat_q <= lat_q - 2'd1;
            end
            if (capture) begin
                rdata_q <= i_api_read_data;
            end
            // Address wraps naturally at 12 bits.
            if (advance) begin
                remaining_q <= remaining_q - 1'b1;
                addr_q      <= addr_q + 1'b1;
            end
        end
    end

    assign o_cmd_ready      = (state_q == IDLE) && !i_areset;
    assign o_api_cs         = (state_q == ISSUE);
    assign o_api_we         = o_api_cs && we_q;
    assign o_api_address    = addr_q;
    assign o_api_write_data = wdata_q;
    assign o_rsp_valid      = (state_q == RESP);
    assign o_rsp_data       = rdata_q;
    assign o_rsp_address    = addr_q;
    assign o_rsp_last       = o_rsp_valid && (remaining_q == '0);
    assign o_busy           = (state_q != IDLE);

endmodule

// File: tb/tb_nts_api_initiator.sv
// Bench for the API initiator: directed table, reset/latency corner
// sequences and random commands against a memory-level reference model.
module tb_nts_api_initiator;

    localparam int LAT_A = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DUT A: READ_LATENCY = 1, registered responder backed by a memory
    logic        a_cmd_valid = 0, a_cmd_ready, a_cmd_we = 0;
    logic [11:0] a_cmd_addr = 0;
    logic [31:0] a_cmd_wdata = 0;
    logic [7:0]  a_cmd_count = 0;
    logic        a_cs, a_we, a_rsp_valid, a_rsp_ready = 0, a_last, a_busy;
    logic [11:0] a_addr, a_rsp_addr;
    logic [31:0] a_wdata, a_rdata, a_rsp_data;

    // DUT B: READ_LATENCY = 0, combinational responder
    logic        b_cmd_valid = 0, b_cmd_ready, b_cmd_we = 0;
    logic [11:0] b_cmd_addr = 0;
    logic [31:0] b_cmd_wdata = 0;
    logic [7:0]  b_cmd_count = 0;
    logic        b_cs, b_we, b_rsp_valid, b_rsp_ready = 0, b_last, b_busy;
    logic [11:0] b_addr, b_rsp_addr;
    logic [31:0] b_wdata, b_rdata, b_rsp_data;

    nts_api_initiator #(.READ_LATENCY(LAT_A), .COUNT_WIDTH(8)) dut_a (
        .i_clk(clk), .i_areset(rst),
        .i_cmd_valid(a_cmd_valid), .o_cmd_ready(a_cmd_ready),
        .i_cmd_we(a_cmd_we), .i_cmd_address(a_cmd_addr),
        .i_cmd_write_data(a_cmd_wdata), .i_cmd_count(a_cmd_count),
        .o_api_cs(a_cs), .o_api_we(a_we), .o_api_address(a_addr),
        .o_api_write_data(a_wdata), .i_api_read_data(a_rdata),
        .o_rsp_valid(a_rsp_valid), .i_rsp_ready(a_rsp_ready),
        .o_rsp_data(a_rsp_data), .o_rsp_address(a_rsp_addr),
        .o_rsp_last(a_last), .o_busy(a_busy)
    );

    nts_api_initiator #(.READ_LATENCY(0), .COUNT_WIDTH(8)) dut_b (
        .i_clk(clk), .i_areset(rst),
        .i_cmd_valid(b_cmd_valid), .o_cmd_ready(b_cmd_ready),
        .i_cmd_we(b_cmd_we), .i_cmd_address(b_cmd_addr),
        .i_cmd_write_data(b_cmd_wdata), .i_cmd_count(b_cmd_count),
        .o_api_cs(b_cs), .o_api_we(b_we), .o_api_address(b_addr),
        .o_api_write_data(b_wdata), .i_api_read_data(b_rdata),
        .o_rsp_valid(b_rsp_valid), .i_rsp_ready(b_rsp_ready),
        .o_rsp_data(b_rsp_data), .o_rsp_address(b_rsp_addr),
        .o_rsp_last(b_last), .o_busy(b_busy)
    );

    // Environment: register-file slave on A, pattern slave on B
    logic [31:0] slave_mem [4096];
    always @(posedge clk) begin
        if (a_cs) begin
            if (a_we) slave_mem[a_addr] <= a_wdata;
            else      a_rdata <= slave_mem[a_addr];
        end
    end
    assign b_rdata = 32'h0E01_0D0F ^ {20'h0, b_addr};

    // Reference model: what the addressed memory holds after each command
    logic [31:0] model_mem [4096];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [7:0]  count;
        int          stall_word;
        int          stall_cyc;
        logic [31:0] exp_first;
        logic        chk_first;
    } vec_t;

    vec_t tab [6];

    task automatic wait_ready_a();
        int k = 0;
        while (!a_cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("a_cmd_ready_timeout", 32'(a_cmd_ready), 32'd1);
    endtask

    task automatic run_cmd(input vec_t v);
        logic [11:0] ea;
        logic [31:0] d, a0;
        wait_ready_a();
        a_cmd_valid = 1;
        a_cmd_we    = v.we;
        a_cmd_addr  = v.addr;
        a_cmd_wdata = v.wdata;
        a_cmd_count = v.count;
        @(negedge clk);
        a_cmd_valid = 0;
        a_cmd_we    = ~v.we;
        a_cmd_addr  = ~v.addr;
        if (v.we) begin
            chk("wr_cs", 32'(a_cs), 32'd1);
            chk("wr_we", 32'(a_we), 32'd1);
            chk("wr_addr", 32'(a_addr), 32'(v.addr));
            chk("wr_wdata", a_wdata, v.wdata);
            chk("wr_no_rsp", 32'(a_rsp_valid), 32'd0);
            model_mem[v.addr] = v.wdata;
            @(negedge clk);
            chk("wr_cs_one_cycle", 32'(a_cs), 32'd0);
            chk("wr_ready_after", 32'(a_cmd_ready), 32'd1);
            chk("wr_no_rsp2", 32'(a_rsp_valid), 32'd0);
        end else begin
            for (int i = 0; i <= int'(v.count); i++) begin
                ea = v.addr + 12'(i);
                chk("rd_cs", 32'(a_cs), 32'd1);
                chk("rd_cs_addr", 32'(a_addr), 32'(ea));
                chk("rd_we", 32'(a_we), 32'd0);
                for (int j = 0; j < LAT_A; j++) begin
                    @(negedge clk);
                    chk("wait_cs", 32'(a_cs), 32'd0);
                    chk("wait_rsp", 32'(a_rsp_valid), 32'd0);
                end
                @(negedge clk);
                chk("rsp_valid", 32'(a_rsp_valid), 32'd1);
                chk("rsp_cs_low", 32'(a_cs), 32'd0);
                chk("rsp_data", a_rsp_data, model_mem[ea]);
                chk("rsp_addr", 32'(a_rsp_addr), 32'(ea));
                chk("rsp_last", 32'(a_last), 32'(i == int'(v.count)));
                if (i == 0 && v.chk_first)
                    chk("rsp_first", a_rsp_data, v.exp_first);
                if (i == v.stall_word) begin
                    d  = a_rsp_data;
                    a0 = 32'(a_rsp_addr);
                    for (int s = 0; s < v.stall_cyc; s++) begin
                        @(negedge clk);
                        chk("stall_valid", 32'(a_rsp_valid), 32'd1);
                        chk("stall_data", a_rsp_data, d);
                        chk("stall_addr", 32'(a_rsp_addr), a0);
                        chk("stall_cs", 32'(a_cs), 32'd0);
                    end
                end
                a_rsp_ready = 1;
                @(negedge clk);
                a_rsp_ready = 0;
            end
            chk("rd_done_ready", 32'(a_cmd_ready), 32'd1);
            chk("rd_done_valid", 32'(a_rsp_valid), 32'd0);
            chk("rd_done_busy", 32'(a_busy), 32'd0);
        end
    endtask

    initial begin
        vec_t r;
        logic cs_seen;
        for (int i = 0; i < 4096; i++) begin
            slave_mem[i] = {20'h0, 12'(i)};
            model_mem[i] = {20'h0, 12'(i)};
        end

        tab[0] = '{1'b1, 12'h023, 32'h0000_0009, 8'd0, -1, 0, 32'h0, 1'b0};
        tab[1] = '{1'b0, 12'h082, 32'h0, 8'd0, -1, 0, 32'h0000_0082, 1'b1};
        tab[2] = '{1'b0, 12'hFFE, 32'h0, 8'd3, -1, 0, 32'h0000_0FFE, 1'b1};
        tab[3] = '{1'b0, 12'h021, 32'h0, 8'd3, 1, 5, 32'h0000_0021, 1'b1};
        tab[4] = '{1'b1, 12'hFFF, 32'hDEAD_BEEF, 8'd0, -1, 0, 32'h0, 1'b0};
        tab[5] = '{1'b0, 12'hFFF, 32'h0, 8'd1, 0, 2, 32'hDEAD_BEEF, 1'b1};

        rst = 1;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(a_cmd_ready), 32'd0);
        chk("rst_cs", 32'(a_cs), 32'd0);
        chk("rst_addr", 32'(a_addr), 32'd0);
        chk("rst_wdata", a_wdata, 32'd0);
        chk("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
        chk("rst_rsp_data", a_rsp_data, 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        rst = 0;
        @(negedge clk);
        chk("post_rst_ready", 32'(a_cmd_ready), 32'd1);

        for (int t = 0; t < 6; t++) run_cmd(tab[t]);

        // Reset while word 2 of a burst is waiting for its sample
        wait_ready_a();
        a_cmd_valid = 1; a_cmd_we = 0; a_cmd_addr = 12'h100; a_cmd_count = 8'd3;
        @(negedge clk);
        a_cmd_valid = 0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_rsp0", 32'(a_rsp_valid), 32'd1);
        a_rsp_ready = 1;
        @(negedge clk);
        a_rsp_ready = 0;
        chk("mid_cs1_addr", 32'(a_addr), 32'h101);
        @(negedge clk);
        chk("mid_wait", 32'(a_busy), 32'd1);
        rst = 1;
        @(negedge clk);
        chk("abort_cmd_ready", 32'(a_cmd_ready), 32'd0);
        chk("abort_cs", 32'(a_cs), 32'd0);
        chk("abort_rsp_valid", 32'(a_rsp_valid), 32'd0);
        chk("abort_busy", 32'(a_busy), 32'd0);
        chk("abort_addr", 32'(a_addr), 32'd0);
        chk("abort_rsp_data", a_rsp_data, 32'd0);
        chk("abort_last", 32'(a_last), 32'd0);
        rst = 0;
        cs_seen = 0;
        repeat (6) begin
            @(negedge clk);
            cs_seen |= a_cs | a_rsp_valid;
        end
        chk("abort_quiet", 32'(cs_seen), 32'd0);
        r = '{1'b0, 12'h100, 32'h0, 8'd1, -1, 0, 32'h0000_0100, 1'b1};
        run_cmd(r);

        // Zero-latency responder: sample in the cs cycle, wrap 0xFFF->0x000
        b_cmd_valid = 1; b_cmd_we = 0; b_cmd_addr = 12'hFFF; b_cmd_count = 8'd1;
        @(negedge clk);
        b_cmd_valid = 0;
        chk("b_cs0", 32'(b_cs), 32'd1);
        chk("b_cs0_addr", 32'(b_addr), 32'hFFF);
        @(negedge clk);
        chk("b_rsp0_valid", 32'(b_rsp_valid), 32'd1);
        chk("b_rsp0_data", b_rsp_data, 32'h0E01_0D0F ^ 32'hFFF);
        chk("b_rsp0_last", 32'(b_last), 32'd0);
        b_rsp_ready = 1;
        @(negedge clk);
        b_rsp_ready = 0;
        chk("b_cs1_addr", 32'(b_addr), 32'h000);
        chk("b_cs1", 32'(b_cs), 32'd1);
        @(negedge clk);
        chk("b_rsp1_data", b_rsp_data, 32'h0E01_0D0F);
        chk("b_rsp1_last", 32'(b_last), 32'd1);
        b_rsp_ready = 1;
        @(negedge clk);
        b_rsp_ready = 0;
        chk("b_done_ready", 32'(b_cmd_ready), 32'd1);

        // Random commands against the memory model
        for (int n = 0; n < 30; n++) begin
            r.we         = ($urandom_range(0, 2) == 0);
            r.addr       = 12'($urandom);
            r.wdata      = $urandom;
            r.count      = 8'($urandom_range(0, 4));
            r.stall_word = $urandom_range(0, 5);
            r.stall_cyc  = $urandom_range(0, 3);
            r.exp_first  = 32'h0;
            r.chk_first  = 1'b0;
            run_cmd(r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
